// File: rtl/frame_cfg_pkg.sv
// Shared types for the frame-synchronous configuration controller.
//   cfg_t    : one channel's modem configuration (modulation, spreading,
//              bandwidth, data-off flag)
//   CFG_RST  : configuration loaded into every register on reset
//   ch_width : channel-index width, never below 1 bit
package frame_cfg_pkg;

  localparam int CFG_M_W  = 3;
  localparam int CFG_SS_W = 4;
  localparam int CFG_BW_W = 3;

  typedef struct packed {
    logic [CFG_M_W-1:0]  m;
    logic [CFG_SS_W-1:0] ss;
    logic [CFG_BW_W-1:0] bw;
    logic                data_off;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    m:        CFG_M_W'(1),
    ss:       CFG_SS_W'(1),
    bw:       '0,
    data_off: 1'b0
  };

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_cfg_ctrl_cfg_bank.sv
// cfg_bank: configuration storage for a single channel.
//   Holds the shadow config written by the host, the active TX and RX
//   configs, and the per-direction pending flags.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_cfg     write shadow with wr_cfg (sets both pending flags)
//   sof_tx, sof_rx    start-of-frame strobes; commit shadow if pending
//   tx_cfg            active TX config (including data_off)
//   rx_m/rx_ss/rx_bw  active RX config (RX has no data_off)
//   pend_tx, pend_rx  shadow not yet committed to that direction
module cfg_bank
  import frame_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  cfg_t                wr_cfg,
  input  logic                sof_tx,
  input  logic                sof_rx,
  output cfg_t                tx_cfg,
  output logic [CFG_M_W-1:0]  rx_m,
  output logic [CFG_SS_W-1:0] rx_ss,
  output logic [CFG_BW_W-1:0] rx_bw,
  output logic                pend_tx,
  output logic                pend_rx
);

  cfg_t                shadow_reg;
  cfg_t                tx_reg;
  logic [CFG_M_W-1:0]  rx_m_reg;
  logic [CFG_SS_W-1:0] rx_ss_reg;
  logic [CFG_BW_W-1:0] rx_bw_reg;
  logic                pend_tx_reg, pend_tx_next;
  logic                pend_rx_reg, pend_rx_next;
  logic                commit_tx, commit_rx;

  assign commit_tx = sof_tx && pend_tx_reg;
  assign commit_rx = sof_rx && pend_rx_reg;

  // A write in the same cycle as a commit re-arms the flag: set beats clear.
  assign pend_tx_next = wr_en || (pend_tx_reg && !sof_tx);
  assign pend_rx_next = wr_en || (pend_rx_reg && !sof_rx);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg  <= CFG_RST;
      tx_reg      <= CFG_RST;
      rx_m_reg    <= CFG_RST.m;
      rx_ss_reg   <= CFG_RST.ss;
      rx_bw_reg   <= CFG_RST.bw;
      pend_tx_reg <= 1'b0;
      pend_rx_reg <= 1'b0;
    end else begin
      // Commits read the shadow value from before this edge, so a
      // coincident write is held back until the next frame.
      if (commit_tx) begin
        tx_reg <= shadow_reg;
      end
      if (commit_rx) begin
        rx_m_reg  <= shadow_reg.m;
        rx_ss_reg <= shadow_reg.ss;
        rx_bw_reg <= shadow_reg.bw;
      end
      if (wr_en) begin
        shadow_reg <= wr_cfg;
      end
      pend_tx_reg <= pend_tx_next;
      pend_rx_reg <= pend_rx_next;
    end
  end

  assign tx_cfg  = tx_reg;
  assign rx_m    = rx_m_reg;
  assign rx_ss   = rx_ss_reg;
  assign rx_bw   = rx_bw_reg;
  assign pend_tx = pend_tx_reg;
  assign pend_rx = pend_rx_reg;

endmodule

// File: rtl/frame_cfg_ctrl.sv
// frame_cfg_ctrl: multi-channel frame-synchronous modem configuration
// controller. Host writes land in per-channel shadow registers and are
// committed to the active TX/RX config only on that channel's start of
// frame. Also produces a delayed reset-release flag that gates writes.
// Optional feature: define CFG_RANGE_CHECK_EN to reject writes with
// cfg_m > M_MAX or cfg_ss == 0 (handshaken, no state change, cfg_err pulse).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cfg_valid / cfg_ready      write handshake (cfg_ready = del_rst)
//   cfg_ch                     target channel; out-of-range is a no-op
//   cfg_m/ss/bw/data_off       new configuration fields
//   cfg_err                    1-cycle reject pulse (0 without range check)
//   sof_tx, sof_rx             per-channel start-of-frame strobes
//   tx_m/ss/bw, tx_data_off    active TX config, channel i at [i*W +: W]
//   rx_m/ss/bw                 active RX config
//   pend_tx, pend_rx           per-channel uncommitted-shadow flags
//   del_rst                    delayed reset-release flag
module frame_cfg_ctrl
  import frame_cfg_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int M_W     = CFG_M_W,
  parameter int SS_W    = CFG_SS_W,
  parameter int BW_W    = CFG_BW_W,
  parameter int RST_DLY = 100,
  parameter int M_MAX   = 5,
  localparam int CH_W   = ch_width(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [M_W-1:0]       cfg_m,
  input  logic [SS_W-1:0]      cfg_ss,
  input  logic [BW_W-1:0]      cfg_bw,
  input  logic                 cfg_data_off,
  output logic                 cfg_err,
  input  logic [N_CH-1:0]      sof_tx,
  input  logic [N_CH-1:0]      sof_rx,
  output logic [N_CH*M_W-1:0]  tx_m,
  output logic [N_CH*SS_W-1:0] tx_ss,
  output logic [N_CH*BW_W-1:0] tx_bw,
  output logic [N_CH-1:0]      tx_data_off,
  output logic [N_CH*M_W-1:0]  rx_m,
  output logic [N_CH*SS_W-1:0] rx_ss,
  output logic [N_CH*BW_W-1:0] rx_bw,
  output logic [N_CH-1:0]      pend_tx,
  output logic [N_CH-1:0]      pend_rx,
  output logic                 del_rst
);

  localparam int CNT_W = $clog2(RST_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RST_DLY);
  localparam logic [CH_W:0]    N_CH_V    = (CH_W+1)'(N_CH);
  localparam logic [M_W:0]     M_MAX_V   = (M_W+1)'(M_MAX);

  // ---------------- reset-release delay ----------------
  logic [CNT_W-1:0] cnt_reg;
  logic             del_rst_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      del_rst_reg <= 1'b0;
    end else begin
      if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      // Registered from the saturated count: rises one edge after the
      // counter reaches RST_DLY.
      del_rst_reg <= (cnt_reg == CNT_MAX);
    end
  end

  assign del_rst   = del_rst_reg;
  assign cfg_ready = del_rst_reg;

  // ---------------- write decode / range check ----------------
  logic wr_acc;
  logic ch_ok;
  logic range_bad;
  logic wr_take;

  assign wr_acc    = cfg_valid && del_rst_reg;
  assign ch_ok     = ({1'b0, cfg_ch} < N_CH_V);
  assign range_bad = ({1'b0, cfg_m} > M_MAX_V) || (cfg_ss == '0);

`ifdef CFG_RANGE_CHECK_EN
  logic cfg_err_reg;

  assign wr_take = wr_acc && ch_ok && !range_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= wr_acc && range_bad;
    end
  end

  assign cfg_err = cfg_err_reg;
`else
  logic unused_range;

  assign wr_take      = wr_acc && ch_ok;
  assign unused_range = range_bad;
  assign cfg_err      = 1'b0;
`endif

  cfg_t wr_cfg;

  assign wr_cfg.m        = cfg_m;
  assign wr_cfg.ss       = cfg_ss;
  assign wr_cfg.bw       = cfg_bw;
  assign wr_cfg.data_off = cfg_data_off;

  // ---------------- per-channel banks ----------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      cfg_t                tx_cfg;
      logic [CFG_M_W-1:0]  ch_rx_m;
      logic [CFG_SS_W-1:0] ch_rx_ss;
      logic [CFG_BW_W-1:0] ch_rx_bw;
      logic                wr_en;

      assign wr_en = wr_take && (cfg_ch == CH_W'(gi));

      cfg_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_cfg  (wr_cfg),
        .sof_tx  (sof_tx[gi]),
        .sof_rx  (sof_rx[gi]),
        .tx_cfg  (tx_cfg),
        .rx_m    (ch_rx_m),
        .rx_ss   (ch_rx_ss),
        .rx_bw   (ch_rx_bw),
        .pend_tx (pend_tx[gi]),
        .pend_rx (pend_rx[gi])
      );

      assign tx_m[gi*M_W +: M_W]    = tx_cfg.m;
      assign tx_ss[gi*SS_W +: SS_W] = tx_cfg.ss;
      assign tx_bw[gi*BW_W +: BW_W] = tx_cfg.bw;
      assign tx_data_off[gi]        = tx_cfg.data_off;
      assign rx_m[gi*M_W +: M_W]    = ch_rx_m;
      assign rx_ss[gi*SS_W +: SS_W] = ch_rx_ss;
      assign rx_bw[gi*BW_W +: BW_W] = ch_rx_bw;
    end
  endgenerate

endmodule

// File: tb/tb_frame_cfg_ctrl.sv
// Testbench for frame_cfg_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural channel model.
module tb_frame_cfg_ctrl;

  localparam int N_CH    = 4;
  localparam int M_W     = 3;
  localparam int SS_W    = 4;
  localparam int BW_W    = 3;
  localparam int RST_DLY = 100;
  localparam int M_MAX   = 5;
  localparam int CH_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch = '0;
  logic [M_W-1:0]       cfg_m = '0;
  logic [SS_W-1:0]      cfg_ss = '0;
  logic [BW_W-1:0]      cfg_bw = '0;
  logic                 cfg_data_off = 1'b0;
  logic                 cfg_err;
  logic [N_CH-1:0]      sof_tx = '0;
  logic [N_CH-1:0]      sof_rx = '0;
  logic [N_CH*M_W-1:0]  tx_m;
  logic [N_CH*SS_W-1:0] tx_ss;
  logic [N_CH*BW_W-1:0] tx_bw;
  logic [N_CH-1:0]      tx_data_off;
  logic [N_CH*M_W-1:0]  rx_m;
  logic [N_CH*SS_W-1:0] rx_ss;
  logic [N_CH*BW_W-1:0] rx_bw;
  logic [N_CH-1:0]      pend_tx;
  logic [N_CH-1:0]      pend_rx;
  logic                 del_rst;

  frame_cfg_ctrl #(
    .N_CH(N_CH), .M_W(M_W), .SS_W(SS_W), .BW_W(BW_W),
    .RST_DLY(RST_DLY), .M_MAX(M_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_m(cfg_m), .cfg_ss(cfg_ss), .cfg_bw(cfg_bw),
    .cfg_data_off(cfg_data_off), .cfg_err(cfg_err),
    .sof_tx(sof_tx), .sof_rx(sof_rx),
    .tx_m(tx_m), .tx_ss(tx_ss), .tx_bw(tx_bw), .tx_data_off(tx_data_off),
    .rx_m(rx_m), .rx_ss(rx_ss), .rx_bw(rx_bw),
    .pend_tx(pend_tx), .pend_rx(pend_rx), .del_rst(del_rst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int sh_m[N_CH], sh_ss[N_CH], sh_bw[N_CH], sh_do[N_CH];
  int t_m[N_CH],  t_ss[N_CH],  t_bw[N_CH],  t_do[N_CH];
  int r_m[N_CH],  r_ss[N_CH],  r_bw[N_CH];
  bit p_tx[N_CH], p_rx[N_CH];
  int low_edges = 0;
  bit m_del = 0;
  bit m_err = 0;

  // One clock edge of the specified behaviour, using the inputs held across it.
  task automatic model_edge();
    bit acc, reject;
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        sh_m[c] = 1; sh_ss[c] = 1; sh_bw[c] = 0; sh_do[c] = 0;
        t_m[c]  = 1; t_ss[c]  = 1; t_bw[c]  = 0; t_do[c]  = 0;
        r_m[c]  = 1; r_ss[c]  = 1; r_bw[c]  = 0;
        p_tx[c] = 0; p_rx[c] = 0;
      end
      low_edges = 0;
      m_del = 0;
      m_err = 0;
    end else begin
      acc = cfg_valid && m_del;
`ifdef CFG_RANGE_CHECK_EN
      reject = (int'(cfg_m) > M_MAX) || (cfg_ss == 0);
`else
      reject = 0;
`endif
      m_err = acc && reject;
      for (int c = 0; c < N_CH; c++) begin
        if (sof_tx[c] && p_tx[c]) begin
          t_m[c] = sh_m[c]; t_ss[c] = sh_ss[c]; t_bw[c] = sh_bw[c]; t_do[c] = sh_do[c];
          p_tx[c] = 0;
        end
        if (sof_rx[c] && p_rx[c]) begin
          r_m[c] = sh_m[c]; r_ss[c] = sh_ss[c]; r_bw[c] = sh_bw[c];
          p_rx[c] = 0;
        end
      end
      if (acc && !reject && int'(cfg_ch) < N_CH) begin
        sh_m[cfg_ch] = cfg_m; sh_ss[cfg_ch] = cfg_ss;
        sh_bw[cfg_ch] = cfg_bw; sh_do[cfg_ch] = cfg_data_off;
        p_tx[cfg_ch] = 1; p_rx[cfg_ch] = 1;
      end
      if (low_edges < 1000) low_edges++;
      m_del = (low_edges > RST_DLY);
    end
  endtask

  task automatic compare_all();
    logic [31:0] e_ptx, e_prx, e_tdo, e_tm, e_tss, e_tbw, e_rm, e_rss, e_rbw;
    e_ptx = 0; e_prx = 0; e_tdo = 0; e_tm = 0; e_tss = 0; e_tbw = 0;
    e_rm = 0; e_rss = 0; e_rbw = 0;
    for (int c = 0; c < N_CH; c++) begin
      e_ptx = e_ptx | (32'(p_tx[c]) << c);
      e_prx = e_prx | (32'(p_rx[c]) << c);
      e_tdo = e_tdo | (32'(t_do[c]) << c);
      e_tm  = e_tm  | (32'(t_m[c])  << (c*M_W));
      e_tss = e_tss | (32'(t_ss[c]) << (c*SS_W));
      e_tbw = e_tbw | (32'(t_bw[c]) << (c*BW_W));
      e_rm  = e_rm  | (32'(r_m[c])  << (c*M_W));
      e_rss = e_rss | (32'(r_ss[c]) << (c*SS_W));
      e_rbw = e_rbw | (32'(r_bw[c]) << (c*BW_W));
    end
    check("del_rst",   32'(del_rst),     32'(m_del));
    check("cfg_ready", 32'(cfg_ready),   32'(m_del));
    check("cfg_err",   32'(cfg_err),     32'(m_err));
    check("pend_tx",   32'(pend_tx),     e_ptx);
    check("pend_rx",   32'(pend_rx),     e_prx);
    check("tx_m",      32'(tx_m),        e_tm);
    check("tx_ss",     32'(tx_ss),       e_tss);
    check("tx_bw",     32'(tx_bw),       e_tbw);
    check("tx_doff",   32'(tx_data_off), e_tdo);
    check("rx_m",      32'(rx_m),        e_rm);
    check("rx_ss",     32'(rx_ss),       e_rss);
    check("rx_bw",     32'(rx_bw),       e_rbw);
  endtask

  // Drive one cycle of inputs, let the edge happen, then model and compare.
  task automatic step(input bit v, input int ch, input int m, input int ss, input int bw,
                      input bit doff, input logic [N_CH-1:0] stx, input logic [N_CH-1:0] srx);
    @(negedge clk);
    cfg_valid    = v;
    cfg_ch       = CH_W'(ch);
    cfg_m        = M_W'(m);
    cfg_ss       = SS_W'(ss);
    cfg_bw       = BW_W'(bw);
    cfg_data_off = doff;
    sof_tx       = stx;
    sof_rx       = srx;
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    // ---------- reset and release delay ----------
    rst = 1;
    repeat (3) idle();
    check("rst_del", 32'(del_rst), 32'd0);
    check("rst_pend", 32'(pend_tx | pend_rx), 32'd0);
    rst = 0;
    for (int k = 1; k <= RST_DLY + 1; k++) begin
      // A write attempted before release must be ignored.
      step(k == 50, 2, 3, 3, 3, 1, '0, '0);
      if (k == RST_DLY) check("del_at_100", 32'(del_rst), 32'd0);
      if (k == RST_DLY + 1) check("del_at_101", 32'(del_rst), 32'd1);
    end
    check("early_wr_ignored", 32'(pend_tx[2]), 32'd0);

    // ---------- write ch2 then sof_tx[2] ----------
    step(1, 2, 4, 8, 2, 0, '0, '0);
    idle();
    step(0, 0, 0, 0, 0, 0, 4'b0100, '0);
    check("ch2_tx_m",  32'(tx_m[2*M_W +: M_W]),    32'd4);
    check("ch2_tx_ss", 32'(tx_ss[2*SS_W +: SS_W]), 32'd8);
    check("ch2_tx_bw", 32'(tx_bw[2*BW_W +: BW_W]), 32'd2);
    check("ch2_rx_m",  32'(rx_m[2*M_W +: M_W]),    32'd1);
    check("ch2_prx",   32'(pend_rx[2]),            32'd1);
    step(0, 0, 0, 0, 0, 0, '0, 4'b0100);
    check("ch2_rx_m2", 32'(rx_m[2*M_W +: M_W]),    32'd4);
    check("ch2_prx2",  32'(pend_rx[2]),            32'd0);

    // ---------- write and sof on ch1 in the same cycle ----------
    step(1, 1, 3, 1, 0, 0, 4'b0010, '0);
    check("ch1_old_m", 32'(tx_m[1*M_W +: M_W]), 32'd1);
    check("ch1_ptx",   32'(pend_tx[1]),         32'd1);
    step(0, 0, 0, 0, 0, 0, 4'b0010, '0);
    check("ch1_new_m", 32'(tx_m[1*M_W +: M_W]), 32'd3);

    // ---------- last write wins ----------
    step(1, 0, 2, 1, 0, 0, '0, '0);
    step(1, 0, 5, 1, 0, 0, '0, '0);
    step(0, 0, 0, 0, 0, 0, '0, 4'b0001);
    check("ch0_rx_m", 32'(rx_m[0 +: M_W]), 32'd5);

    // ---------- out-of-range M ----------
    step(1, 3, 7, 2, 1, 1, '0, '0);
`ifdef CFG_RANGE_CHECK_EN
    check("m7_err",  32'(cfg_err),    32'd1);
    check("m7_pend", 32'(pend_tx[3]), 32'd0);
`else
    check("m7_err",  32'(cfg_err),    32'd0);
    check("m7_pend", 32'(pend_tx[3]), 32'd1);
`endif
    step(0, 0, 0, 0, 0, 0, 4'b1000, '0);
`ifdef CFG_RANGE_CHECK_EN
    check("m7_tx_m", 32'(tx_m[3*M_W +: M_W]), 32'd1);
`else
    check("m7_tx_m", 32'(tx_m[3*M_W +: M_W]), 32'd7);
`endif

    // ---------- simultaneous sofs on all channels ----------
    for (int c = 0; c < N_CH; c++) step(1, c, c + 1, c + 2, c, c[0], '0, '0);
    step(0, 0, 0, 0, 0, 0, 4'b1111, 4'b1111);
    check("all_commit_ptx", 32'(pend_tx), 32'd0);
    check("all_commit_prx", 32'(pend_rx), 32'd0);

    // ---------- randomized traffic with occasional reset ----------
    for (int n = 0; n < 1500; n++) begin
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      step($urandom_range(0, 1) == 1, $urandom_range(0, N_CH - 1),
           $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7),
           $urandom_range(0, 1) == 1,
           N_CH'($urandom_range(0, 15) & $urandom_range(0, 15)),
           N_CH'($urandom_range(0, 15) & $urandom_range(0, 15)));
    end

    // ---------- reset with pending writes ----------
    rst = 0;
    for (int k = 0; k < RST_DLY + 2; k++) idle();
    step(1, 1, 4, 9, 3, 1, '0, '0);
    check("pre_rst_pend", 32'(pend_tx[1]), 32'd1);
    rst = 1;
    idle();
    check("rst_pend_tx", 32'(pend_tx), 32'd0);
    check("rst_pend_rx", 32'(pend_rx), 32'd0);
    check("rst_tx_m",    32'(tx_m),    32'h249);
    check("rst_del2",    32'(del_rst), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
